btn_ctrl: RTL
=============

BTN_CTRL -- requirements
Module: btn_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of consecutive stable cycles required to accept a button change (legal range 2..2^24).
REQ-002 Port: clk_i  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port: rst_i  input  1  reset, synchronous, active-high.
REQ-004 Port: btn_mode_i  input  1  raw mode-select button, active-high, asynchronous to clk_i.
REQ-005 Port: btn_set_i  input  1  raw event/write button, active-high, asynchronous.
REQ-006 Port: btn_rst_i  input  1  raw module-reset button, active-high, asynchronous.
REQ-007 Port: state_o  output  3  one-hot mode: 3'b100 CNT_EN, 3'b010 LRU_WR, 3'b001 LRU_RD.
REQ-008 Port: set_o  output  1  debounced level of btn_set_i.
REQ-009 Port: mod_rst_o  output  1  debounced level of btn_rst_i.
REQ-010 Port: mode_chg_o  output  1  one-cycle pulse in the cycle state_o takes a new value.

Function
REQ-011 Each button SHALL pass through an input stage (see REQ-025/026) and then an independent debouncer with a counter of width clog2(DEBOUNCE_CYCLES).
REQ-012 Debouncer: while input-stage output equals the debounced value, the counter SHALL hold 0; while it differs, the counter SHALL increment by 1 per cycle.
REQ-013 When the counter equals DEBOUNCE_CYCLES-1 and the input still differs, the debounced value SHALL toggle on that edge and the counter SHALL clear; any cycle of agreement before that SHALL clear the counter (glitch rejected).
REQ-014 Debounced value therefore SHALL change exactly DEBOUNCE_CYCLES edges after the first differing input-stage sample, never earlier.
REQ-015 set_o and mod_rst_o SHALL equal the debounced levels directly; no pulse shaping (downstream performs its own edge detection).
REQ-016 Mode FSM states: CNT_EN -> LRU_WR -> LRU_RD -> CNT_EN (wrap-around); state_o SHALL be the state's one-hot code, never any other value.
REQ-017 FSM SHALL advance one step on the edge after a debounced btn_mode rising edge (0->1); holding the button SHALL advance only once; release SHALL have no effect.
REQ-018 A debounced mode rising edge occurring while set_o or mod_rst_o is 1 SHALL be discarded (not queued); the FSM holds state.
REQ-019 mode_chg_o SHALL be 1 for exactly the first cycle in which state_o shows the new state, 0 otherwise.
REQ-020 Simultaneous debounced rises of mode and set/rst in the same cycle: the mode edge SHALL be discarded per REQ-018 (set/rst take priority).

Reset
REQ-021 On rst_i=1 at a clock edge: state_o SHALL become 3'b100, set_o=0, mod_rst_o=0, mode_chg_o=0, all debounce counters 0, all debounced levels and edge-detect registers 0, synchronizer flops 0.
REQ-022 Reset SHALL take priority over any in-progress debounce or mode change; a partially counted change SHALL be lost.
REQ-023 A button held across reset deassertion SHALL be re-debounced from count 0 and, for btn_mode, SHALL count as a rising edge once accepted.
REQ-024 Outputs SHALL reach reset values in the cycle after the reset edge; no output depends combinationally on rst_i.

Configuration
REQ-025 With macro BTN_CTRL_SYNC_EN defined, each raw button SHALL pass through a two-flop synchronizer, adding exactly 2 cycles of latency before the debouncer.
REQ-026 Without BTN_CTRL_SYNC_EN, raw buttons SHALL feed the debouncers directly (0 added latency); all other behaviour identical.

Verification (DEBOUNCE_CYCLES=4, BTN_CTRL_SYNC_EN defined unless stated)
REQ-027 Reset, then idle 10 cycles -> state_o=3'b100, set_o=0, mod_rst_o=0, mode_chg_o=0 throughout.
REQ-028 btn_set_i 0->1 held -> set_o rises exactly 6 edges later (2 sync + 4 debounce); 3-cycle pulse on btn_set_i -> set_o stays 0.
REQ-029 Three clean btn_mode presses (each held 10, released 10 cycles) -> state_o 100->010->001->100, mode_chg_o one cycle per step, 3 pulses total.
REQ-030 btn_set_i held (set_o=1) then btn_mode pressed -> state_o unchanged, mode_chg_o=0; release set, hold mode -> no advance until mode released and re-pressed.
REQ-031 rst_i asserted 2 cycles into a btn_mode debounce while state_o=3'b010 -> state_o=3'b100 next cycle; mode held through reset release -> one advance to 3'b010 after 6 cycles.
REQ-032 Repeat REQ-028 without BTN_CTRL_SYNC_EN -> set_o rises exactly 4 edges after btn_set_i rises.

Source files
------------

// File: rtl/btn_ctrl.sv
// btn_ctrl: debounced front-end for three push buttons (mode, set, reset)
// driving a three-state one-hot mode selector.
//
// Optional build macro: BTN_CTRL_SYNC_EN
//   defined   -> each raw button passes through a two-flop synchronizer
//                (2 extra cycles before the debouncer)
//   undefined -> raw buttons feed the debouncers directly
//
// Mode sequence: CNT_EN (100) -> LRU_WR (010) -> LRU_RD (001) -> CNT_EN.
// A debounced mode press is ignored while set or module-reset is held.

// Single-button debouncer: the output follows the input only after the
// input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module btn_ctrl_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic dout_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             level_q;

    // Count consecutive disagreeing samples; toggle once the run is long enough.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else if (din_i == level_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            level_q <= ~level_q;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign dout_o = level_q;

endmodule

module btn_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_mode_i,
    input  logic       btn_set_i,
    input  logic       btn_rst_i,
    output logic [2:0] state_o,
    output logic       set_o,
    output logic       mod_rst_o,
    output logic       mode_chg_o
);

    // One-hot mode codes; the state register holds these directly.
    localparam logic [2:0] ST_CNT_EN = 3'b100;
    localparam logic [2:0] ST_LRU_WR = 3'b010;
    localparam logic [2:0] ST_LRU_RD = 3'b001;

    // Button vector ordering: [0] mode, [1] set, [2] module reset.
    logic [2:0] btn_raw;
    logic [2:0] btn_stage;
    logic [2:0] btn_db;

    assign btn_raw = {btn_rst_i, btn_set_i, btn_mode_i};

`ifdef BTN_CTRL_SYNC_EN
    logic [2:0] sync_p0;
    logic [2:0] sync_p1;

    // Two-flop synchronizer bringing the asynchronous buttons into clk_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    assign btn_stage = sync_p1;
`else
    assign btn_stage = btn_raw;
`endif

    btn_ctrl_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_mode (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .din_i (btn_stage[0]),
        .dout_o(btn_db[0])
    );

    btn_ctrl_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_set (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .din_i (btn_stage[1]),
        .dout_o(btn_db[1])
    );

    btn_ctrl_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_rst (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .din_i (btn_stage[2]),
        .dout_o(btn_db[2])
    );

    logic [2:0] state_q;
    logic [2:0] state_nxt;
    logic       mode_prev_q;
    logic       mode_chg_q;
    logic       mode_rise;
    logic       mode_adv;

    // A held set/reset button swallows the mode press rather than deferring it.
    assign mode_rise = btn_db[0] & ~mode_prev_q;
    assign mode_adv  = mode_rise & ~btn_db[1] & ~btn_db[2];

    // Successor in the wrap-around mode ring; unknown codes recover to CNT_EN.
    always_comb begin
        state_nxt = ST_CNT_EN;
        case (state_q)
            ST_CNT_EN: state_nxt = ST_LRU_WR;
            ST_LRU_WR: state_nxt = ST_LRU_RD;
            ST_LRU_RD: state_nxt = ST_CNT_EN;
            default:   state_nxt = ST_CNT_EN;
        endcase
    end

    // Mode register, edge-detect history and the one-cycle change strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_CNT_EN;
            mode_prev_q <= 1'b0;
            mode_chg_q  <= 1'b0;
        end else begin
            mode_prev_q <= btn_db[0];
            mode_chg_q  <= mode_adv;
            if (mode_adv) begin
                state_q <= state_nxt;
            end
        end
    end

    assign state_o    = state_q;
    assign set_o      = btn_db[1];
    assign mod_rst_o  = btn_db[2];
    assign mode_chg_o = mode_chg_q;

endmodule
